// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8N1 frame reception with a multi-flop rx synchronizer.
// Samples at bit mid-points and flags a low stop bit as a framing error.
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b_tick,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [7:0]             shreg;
    logic [3:0]             b_cnt;
    logic [2:0]             bit_cnt;

    // Idle-high reset value keeps a reset release from looking like a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            b_cnt     <= 4'd0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        b_cnt   <= 4'd0;
                        rx_busy <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (b_tick) begin
                        if (b_cnt == 4'd7) begin
                            // Line back high at the mid-point means a glitch, not a start bit.
                            if (!rx_s) begin
                                b_cnt   <= 4'd0;
                                bit_cnt <= 3'd0;
                                state   <= DATA;
                            end else begin
                                rx_busy <= 1'b0;
                                state   <= IDLE;
                            end
                        end else begin
                            b_cnt <= b_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (b_tick) begin
                        if (b_cnt == 4'd15) begin
                            shreg <= {rx_s, shreg[7:1]};
                            b_cnt <= 4'd0;
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else begin
                            b_cnt <= b_cnt + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (b_tick) begin
                        if (b_cnt == 4'd15) begin
                            // Leave at the stop mid-point so a directly following start bit is caught.
                            rx_data   <= shreg;
                            rx_done   <= 1'b1;
                            frame_err <= ~rx_s;
                            rx_busy   <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            b_cnt <= b_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    rx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
